// File: rtl/sha256_nonce_checker_pkg.sv
// Constants shared between the nonce checker and the double-SHA256 pipeline build.
package sha256_nonce_checker_pkg;

    localparam int          PIPELINE_LATENCY = 67;
    localparam logic [31:0] IV7              = 32'h5be0cd19;
    // A share is H7 + IV7 == 0, so the pre-IV-add word must equal -IV7.
    localparam logic [31:0] MATCH_H7_SHARE   = 32'h0 - IV7;
    localparam int          GN_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sha256_nonce_checker_gn_fifo.sv
// First-word-fall-through golden-nonce queue; a push into a full queue is taken only alongside a pop.
module gn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_nonce_checker.sv
// Issues nonces to the hashing pipeline, tags them through its latency and queues nonces whose hash is a share.
// state | meaning:  IDLE | no scan;  RUN | one nonce issued per clock;  DRAIN | waiting for the last hashes
module sha256_nonce_checker
    import sha256_nonce_checker_pkg::*;
#(
    parameter int          PIPE_LATENCY = PIPELINE_LATENCY,
    parameter logic [31:0] MATCH_H7     = MATCH_H7_SHARE,
    parameter int          FIFO_DEPTH   = GN_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  nonce_base,
    input  logic [31:0]  nonce_last,
    output logic [31:0]  nonce_out,
    input  logic [255:0] hash_in,
    output logic         gn_valid,
    input  logic         gn_ready,
    output logic [31:0]  gn_nonce,
    output logic         busy,
    output logic         done,
    output logic         overflow
);
    localparam int DW = $clog2(PIPE_LATENCY + 1);

    scan_state_t             state;
    scan_state_t             state_next;
    logic [31:0]             last_q;
    logic [31:0]             issue_cnt;
    logic [31:0]             rx_nonce;
    logic [31:0]             match_nonce;
    logic [PIPE_LATENCY-1:0] tag_line;
    logic [DW-1:0]           drain_cnt;
    logic                    tag_out;
    logic                    hit;
    logic                    match_q;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    overflow_q;
    logic                    done_q;
    logic                    unused_hash;

    // Only H7 decides a share; the lower hash words pass by unexamined.
    assign unused_hash = ^hash_in[223:0];

    assign tag_out  = tag_line[PIPE_LATENCY-1];
    assign rx_nonce = issue_cnt - 32'(PIPE_LATENCY);
    assign hit      = tag_out && (hash_in[255:224] == MATCH_H7);
    assign pop      = gn_valid && gn_ready;
    assign gn_valid = !fifo_empty;
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            RUN:     if (nonce_out == last_q) state_next = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_out   <= '0;
            last_q      <= '0;
            issue_cnt   <= '0;
            tag_line    <= '0;
            drain_cnt   <= '0;
            match_q     <= 1'b0;
            match_nonce <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && (state_next == IDLE);
            if (start) begin
                // Restart: anything still in the pipeline belongs to the old job.
                nonce_out  <= nonce_base;
                last_q     <= nonce_last;
                issue_cnt  <= nonce_base;
                tag_line   <= '0;
                match_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                tag_line <= {tag_line[PIPE_LATENCY-2:0], (state == RUN)};
                if ((state == RUN) && (state_next == RUN)) begin
                    nonce_out <= nonce_out + 32'd1;
                end
                // Keeps counting through DRAIN so rx_nonce stays aligned with the tag line.
                if (state != IDLE) begin
                    issue_cnt <= issue_cnt + 32'd1;
                end
                match_q     <= hit;
                match_nonce <= rx_nonce;
                if (match_q && fifo_full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end
            if ((state == RUN) && (state_next == DRAIN)) begin
                drain_cnt <= DW'(PIPE_LATENCY - 1);
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    gn_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_gn_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (match_q),
        .pop   (pop),
        .wdata (match_nonce),
        .rdata (gn_nonce),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sha256_nonce_checker.sv
// Self-checking bench: delay-line pipeline model, cycle-level scoreboard of scan timing and golden-nonce queue.
module tb_sha256_nonce_checker;

    localparam int          LAT      = 67;
    localparam logic [31:0] SHARE_H7 = 32'ha41f32e7;
    localparam int          DEPTH    = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  nonce_base = '0;
    logic [31:0]  nonce_last = '0;
    logic [31:0]  nonce_out;
    logic [255:0] hash_in;
    logic         gn_valid;
    logic         gn_ready = 1'b0;
    logic [31:0]  gn_nonce;
    logic         busy;
    logic         done;
    logic         overflow;

    always #5 clk = ~clk;

    sha256_nonce_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .nonce_base (nonce_base),
        .nonce_last (nonce_last),
        .nonce_out  (nonce_out),
        .hash_in    (hash_in),
        .gn_valid   (gn_valid),
        .gn_ready   (gn_ready),
        .gn_nonce   (gn_nonce),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    // Pipeline model: H7 of nonce N appears LAT clocks after N was presented.
    bit          match_map [logic [31:0]];
    logic [31:0] pipe_h7 [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) pipe_h7[i] = SHARE_H7 ^ 32'h0000_0100;
    end

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe_h7[i] <= pipe_h7[i-1];
        pipe_h7[0] <= match_map.exists(nonce_out) ? SHARE_H7 : (SHARE_H7 ^ 32'h0000_0100);
    end

    assign hash_in = {pipe_h7[LAT-1], {7{32'h6a09e667}}};

    // Reference model state
    int          errors = 0;
    int          checks = 0;
    longint      cyc = 0;
    logic [31:0] q [$];
    bit          ovf_m = 1'b0;
    bit          has_run = 1'b0;
    longint      s_cyc = 0;
    longint      run_len = 0;
    logic [31:0] run_base = '0;
    logic [31:0] run_last = '0;
    logic [31:0] push_at [longint];
    longint      last_done = -1;
    int          pops = 0;
    logic [31:0] last_pop = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] en;
        bit          eb;
        bit          ed;
        longint      d;
        en = '0;
        eb = 1'b0;
        ed = 1'b0;
        if (has_run) begin
            d  = cyc - s_cyc;
            en = (d <= run_len) ? run_base + 32'(d - 1) : run_last;
            eb = (d <= run_len + LAT);
            ed = (d == run_len + LAT + 1);
        end
        check("nonce_out", nonce_out, en);
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        check("gn_valid", 32'(gn_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("gn_nonce", gn_nonce, q[0]);
        check("overflow", 32'(overflow), 32'(ovf_m));
        if (done) last_done = cyc;
    endtask

    // Predicts the effect of the coming clock edge, lets it happen, then compares.
    task automatic tick();
        bit          pop_m;
        bit          drop;
        logic [31:0] diff;
        logic [31:0] n;
        drop = 1'b0;
        if (gn_valid && gn_ready) begin
            pops++;
            last_pop = gn_nonce;
        end
        if (rst_n) begin
            pop_m = gn_ready && (q.size() > 0);
            if (pop_m) void'(q.pop_front());
            if (push_at.exists(cyc)) begin
                if (q.size() < DEPTH) q.push_back(push_at[cyc]);
                else drop = 1'b1;
                push_at.delete(cyc);
            end
            if (start) begin
                ovf_m    = 1'b0;
                has_run  = 1'b1;
                s_cyc    = cyc;
                run_base = nonce_base;
                run_last = nonce_last;
                diff     = nonce_last - nonce_base;
                run_len  = longint'({32'd0, diff}) + 1;
                push_at.delete();
                for (longint i = 0; i < run_len; i++) begin
                    n = run_base + 32'(i);
                    if (match_map.exists(n)) push_at[cyc + 1 + i + LAT + 1] = n;
                end
            end else if (drop) begin
                ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic check_reset_values();
        check("rst_nonce_out", nonce_out, 32'h0);
        check("rst_gn_valid", 32'(gn_valid), 32'h0);
        check("rst_gn_nonce", gn_nonce, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] l);
        nonce_base = b;
        nonce_last = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] last;
        logic [31:0] match_lo;
        int          match_cnt;
        bit          ready;
        int          exp_pops;
        bit          exp_ovf;
        int          exp_done_delay;
    } row_t;

    row_t rows [5];

    task automatic run_row(input row_t v);
        longint st;
        match_map.delete();
        for (int k = 0; k < v.match_cnt; k++) match_map[v.match_lo + 32'(k)] = 1'b1;
        gn_ready  = v.ready;
        pops      = 0;
        last_done = -1;
        st        = cyc;
        pulse_start(v.base, v.last);
        for (int k = 0; k < 90; k++) tick();
        check("row_overflow", 32'(overflow), 32'(v.exp_ovf));
        check("row_done_delay", 32'(last_done - st), 32'(v.exp_done_delay));
        gn_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("row_pops", 32'(pops), 32'(v.exp_pops));
    endtask

    initial begin
        longint      s;
        logic [31:0] b;
        int          len;

        rows[0] = '{32'h0000_0100, 32'h0000_010F, 32'h0000_0105, 1, 1'b1, 1, 1'b0, 84};
        rows[1] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 2, 1'b0, 2, 1'b0, 72};
        rows[2] = '{32'h0000_0300, 32'h0000_030F, 32'h0000_0302, 6, 1'b0, 4, 1'b1, 84};
        rows[3] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 1, 1'b1, 1, 1'b0, 69};
        rows[4] = '{32'h0000_0700, 32'h0000_070F, 32'h0000_0000, 0, 1'b1, 0, 1'b0, 84};

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        tick();
        tick();

        for (int r = 0; r < 5; r++) run_row(rows[r]);

        // Restart mid-RUN with 30 old-job matches still inside the pipeline.
        match_map.delete();
        for (int k = 0; k < 30; k++) match_map[32'h1000 + 32'(k)] = 1'b1;
        match_map[32'h2005] = 1'b1;
        gn_ready = 1'b1;
        pops = 0;
        pulse_start(32'h1000, 32'h10FF);
        repeat (39) tick();
        pulse_start(32'h2000, 32'h2010);
        check("restart_first_nonce", nonce_out, 32'h2000);
        repeat (95) tick();
        check("restart_pops", 32'(pops), 32'd1);
        check("restart_nonce", last_pop, 32'h2005);

        // Full queue: a match and a pop on the same edge must both take effect.
        match_map.delete();
        for (int k = 0; k < 4; k++) match_map[32'h400 + 32'(k)] = 1'b1;
        match_map[32'h408] = 1'b1;
        gn_ready = 1'b0;
        s = cyc;
        pulse_start(32'h400, 32'h40F);
        while (cyc < s + 77) tick();
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        check("full_pop_overflow", 32'(overflow), 32'h0);
        repeat (20) tick();
        pops = 0;
        gn_ready = 1'b1;
        repeat (8) tick();
        check("full_pop_count", 32'(pops), 32'd4);
        check("full_pop_last", last_pop, 32'h408);

        // Reset pulse in DRAIN with two nonces queued.
        match_map.delete();
        match_map[32'h500] = 1'b1;
        match_map[32'h501] = 1'b1;
        gn_ready = 1'b0;
        s = cyc;
        pulse_start(32'h500, 32'h50F);
        while (cyc < s + 75) tick();
        check("pre_reset_valid", 32'(gn_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        push_at.delete();
        ovf_m   = 1'b0;
        has_run = 1'b0;
        tick();
        rst_n = 1'b1;
        last_done = -1;
        repeat (100) tick();
        check("no_done_after_reset", 32'(last_done), 32'hFFFF_FFFF);

        // Randomized scans, some wrapping through zero, with random back-pressure.
        for (int t = 0; t < 10; t++) begin
            b   = (t % 3 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            len = $urandom_range(1, 24);
            match_map.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) match_map[b + 32'(k)] = 1'b1;
            end
            gn_ready = 1'b1;
            pulse_start(b, b + 32'(len - 1));
            for (int k = 0; k < len + LAT + 6; k++) begin
                gn_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            gn_ready = 1'b1;
            repeat (6) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
